// File: rtl/axi_lite_mon_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_mon_pkg
// Shared definitions for the AXI4-Lite beat monitor:
//   - bit positions inside the sticky err_o vector
//   - channel enumeration, used to index per-channel handshake/counter vectors
//   - packed per-channel count bundle sized for the default counter width
// -----------------------------------------------------------------------------
package axi_lite_mon_pkg;

   localparam int ERR_W        = 4;
   localparam int ERR_B_ORPHAN = 0;  // B accepted with no open AW and W
   localparam int ERR_R_ORPHAN = 1;  // R accepted with no open AR
   localparam int ERR_OUTST    = 2;  // a pending tracker tried to pass the limit
   localparam int ERR_CNT_OVF  = 3;  // a beat counter was bumped at all-ones

   localparam int NUM_CH    = 5;
   localparam int CNT_W_DEF = 32;

   typedef enum logic [2:0] {
      CH_AW = 3'd0,
      CH_W  = 3'd1,
      CH_B  = 3'd2,
      CH_AR = 3'd3,
      CH_R  = 3'd4
   } ch_e;

   // Snapshot of all five beat counts at the default counter width.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] aw;
      logic [CNT_W_DEF-1:0] w;
      logic [CNT_W_DEF-1:0] b;
      logic [CNT_W_DEF-1:0] ar;
      logic [CNT_W_DEF-1:0] r;
   } beat_counts_t;

endpackage

// File: rtl/axi_lite_mon_ctr.sv
// -----------------------------------------------------------------------------
// axi_lite_mon_ctr
// One beat counter with clear, hold and saturate-or-wrap behaviour.
// Ports:
//   clk_i   in  1  clock
//   rst_i   in  1  synchronous active-high reset
//   inc_i   in  1  count one beat this cycle
//   clr_i   in  1  synchronous clear (wins over hold and increment)
//   hold_i  in  1  freeze the value (wins over increment)
//   cnt_o   out W  registered count
//   ovf_o   out 1  increment attempted while at all-ones (same-cycle strobe,
//                  registered by the parent into its sticky error flag)
// -----------------------------------------------------------------------------
module axi_lite_mon_ctr #(
   parameter int W        = 32,
   parameter bit SATURATE = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   input  logic         hold_i,
   output logic [W-1:0] cnt_o,
   output logic         ovf_o
);

   localparam logic [W-1:0] CNT_ONE = W'(32'd1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count and overflow strobe, in clear > hold > increment order.
   always_comb begin
      cnt_d = cnt_q;
      ovf_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (hold_i) begin
         cnt_d = cnt_q;
      end else if (inc_i) begin
         if (&cnt_q) begin
            ovf_o = 1'b1;
            cnt_d = SATURATE ? cnt_q : '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_lite_beat_monitor.sv
// -----------------------------------------------------------------------------
// axi_lite_beat_monitor
// Passive AXI4-Lite handshake monitor: per-channel beat counters, outstanding
// write/read trackers and sticky protocol-error flags. All outputs come from
// registers; nothing on the inputs reaches an output combinationally.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   clear_i                      zero counters and err_o (trackers untouched)
//   freeze_i                     hold beat counters (trackers keep running)
//   <ch>_valid_i/<ch>_ready_i    monitored handshakes for AW, W, B, AR, R
//   <ch>_cnt_o                   accepted beats per channel
//   wr_aw_pend_o, wr_w_pend_o    AW / W accepted with B still to come
//   rd_pend_o                    AR accepted with R still to come
//   balanced_o                   all three trackers are zero
//   err_o                        sticky error flags, see axi_lite_mon_pkg
// -----------------------------------------------------------------------------
module axi_lite_beat_monitor
   import axi_lite_mon_pkg::*;
#(
   parameter  int CNT_W           = 32,
   parameter  int MAX_OUTSTANDING = 16,
   parameter  bit SATURATE        = 1'b1,
   localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             freeze_i,
   input  logic             aw_valid_i,
   input  logic             aw_ready_i,
   input  logic             w_valid_i,
   input  logic             w_ready_i,
   input  logic             b_valid_i,
   input  logic             b_ready_i,
   input  logic             ar_valid_i,
   input  logic             ar_ready_i,
   input  logic             r_valid_i,
   input  logic             r_ready_i,
   output logic [CNT_W-1:0] aw_cnt_o,
   output logic [CNT_W-1:0] w_cnt_o,
   output logic [CNT_W-1:0] b_cnt_o,
   output logic [CNT_W-1:0] ar_cnt_o,
   output logic [CNT_W-1:0] r_cnt_o,
   output logic [OW-1:0]    wr_aw_pend_o,
   output logic [OW-1:0]    wr_w_pend_o,
   output logic [OW-1:0]    rd_pend_o,
   output logic             balanced_o,
   output logic [ERR_W-1:0] err_o
);

   localparam logic [OW-1:0] TRK_MAX = OW'(MAX_OUTSTANDING);
   localparam logic [OW-1:0] TRK_ONE = OW'(32'd1);

   logic [NUM_CH-1:0] hs_s;
   logic [CNT_W-1:0]  cnt_s [NUM_CH];
   logic [NUM_CH-1:0] ovf_s;

   logic [OW-1:0]    aw_pend_q, aw_pend_d;
   logic [OW-1:0]    w_pend_q,  w_pend_d;
   logic [OW-1:0]    rd_pend_q, rd_pend_d;
   logic             aw_ovf_s, w_ovf_s, rd_ovf_s;
   logic             b_orphan_s, r_orphan_s;
   logic [ERR_W-1:0] err_set_s;
   logic [ERR_W-1:0] err_q, err_d;
   logic             balanced_q, balanced_d;

   // Returns {limit_hit, next}. Callers only assert dec when cur is non-zero,
   // so the decrement never underflows; inc and dec together cancel.
   function automatic logic [OW:0] trk_next(input logic [OW-1:0] cur,
                                            input logic          inc,
                                            input logic          dec);
      logic [OW:0] res;
      res = {1'b0, cur};
      if (inc && !dec) begin
         if (cur == TRK_MAX) begin
            res = {1'b1, cur};
         end else begin
            res = {1'b0, cur + TRK_ONE};
         end
      end else if (dec && !inc) begin
         res = {1'b0, cur - TRK_ONE};
      end else begin
         res = {1'b0, cur};
      end
      return res;
   endfunction

   assign hs_s[CH_AW] = aw_valid_i & aw_ready_i;
   assign hs_s[CH_W]  = w_valid_i  & w_ready_i;
   assign hs_s[CH_B]  = b_valid_i  & b_ready_i;
   assign hs_s[CH_AR] = ar_valid_i & ar_ready_i;
   assign hs_s[CH_R]  = r_valid_i  & r_ready_i;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ctr
      axi_lite_mon_ctr #(
         .W        (CNT_W),
         .SATURATE (SATURATE)
      ) u_ctr (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .inc_i  (hs_s[g]),
         .clr_i  (clear_i),
         .hold_i (freeze_i),
         .cnt_o  (cnt_s[g]),
         .ovf_o  (ovf_s[g])
      );
   end

   // Tracker next state, error detection and the balance flag.
   always_comb begin
      // Orphan checks look only at registered tracker values, so an AW/W
      // arriving alongside the B does not make that B legal.
      b_orphan_s = hs_s[CH_B] && ((aw_pend_q == '0) || (w_pend_q == '0));
      r_orphan_s = hs_s[CH_R] && (rd_pend_q == '0);

      {aw_ovf_s, aw_pend_d} = trk_next(aw_pend_q, hs_s[CH_AW],
                                       hs_s[CH_B] && (aw_pend_q != '0));
      {w_ovf_s, w_pend_d}   = trk_next(w_pend_q, hs_s[CH_W],
                                       hs_s[CH_B] && (w_pend_q != '0));
      {rd_ovf_s, rd_pend_d} = trk_next(rd_pend_q, hs_s[CH_AR],
                                       hs_s[CH_R] && (rd_pend_q != '0));

      err_set_s               = '0;
      err_set_s[ERR_B_ORPHAN] = b_orphan_s;
      err_set_s[ERR_R_ORPHAN] = r_orphan_s;
      err_set_s[ERR_OUTST]    = aw_ovf_s | w_ovf_s | rd_ovf_s;
      err_set_s[ERR_CNT_OVF]  = |ovf_s;

      if (clear_i) begin
         err_d = '0;
      end else begin
         err_d = err_q | err_set_s;
      end

      balanced_d = (aw_pend_d == '0) && (w_pend_d == '0) && (rd_pend_d == '0);
   end

   // Tracker, error and balance registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_pend_q  <= '0;
         w_pend_q   <= '0;
         rd_pend_q  <= '0;
         err_q      <= '0;
         balanced_q <= 1'b1;
      end else begin
         aw_pend_q  <= aw_pend_d;
         w_pend_q   <= w_pend_d;
         rd_pend_q  <= rd_pend_d;
         err_q      <= err_d;
         balanced_q <= balanced_d;
      end
   end

   assign aw_cnt_o     = cnt_s[CH_AW];
   assign w_cnt_o      = cnt_s[CH_W];
   assign b_cnt_o      = cnt_s[CH_B];
   assign ar_cnt_o     = cnt_s[CH_AR];
   assign r_cnt_o      = cnt_s[CH_R];
   assign wr_aw_pend_o = aw_pend_q;
   assign wr_w_pend_o  = w_pend_q;
   assign rd_pend_o    = rd_pend_q;
   assign balanced_o   = balanced_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_axi_lite_beat_monitor.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_beat_monitor
// Three monitors share one stimulus bus:
//   u0  default parameters (32-bit counters, limit 16, saturating)
//   u1  4-bit saturating counters, outstanding limit 2
//   u2  4-bit wrapping counters, limit 16
// A behavioural model of u0 (integer counts and pending totals) is stepped on
// every clock and checked during the random scenario.
// -----------------------------------------------------------------------------
module tb_axi_lite_beat_monitor;
   import axi_lite_mon_pkg::*;

   localparam logic [4:0] M_AW = 5'b00001;
   localparam logic [4:0] M_W  = 5'b00010;
   localparam logic [4:0] M_B  = 5'b00100;
   localparam logic [4:0] M_AR = 5'b01000;
   localparam logic [4:0] M_R  = 5'b10000;
   localparam int         MAXO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       frz = 1'b0;
   logic [4:0] vld = 5'b0;
   logic [4:0] rdy = 5'b0;

   logic [31:0] u0_aw_cnt, u0_w_cnt, u0_b_cnt, u0_ar_cnt, u0_r_cnt;
   logic [4:0]  u0_aw_pend, u0_w_pend, u0_rd_pend;
   logic        u0_bal;
   logic [3:0]  u0_err;
   logic [3:0]  u1_aw_cnt, u1_w_cnt, u1_b_cnt, u1_ar_cnt, u1_r_cnt;
   logic [1:0]  u1_aw_pend, u1_w_pend, u1_rd_pend;
   logic        u1_bal;
   logic [3:0]  u1_err;
   logic [3:0]  u2_aw_cnt, u2_w_cnt, u2_b_cnt, u2_ar_cnt, u2_r_cnt;
   logic [4:0]  u2_aw_pend, u2_w_pend, u2_rd_pend;
   logic        u2_bal;
   logic [3:0]  u2_err;

   int checks = 0;
   int errors = 0;

   // Reference model state for u0
   logic [31:0] m_c [5];
   int          m_aw, m_w, m_rd;
   logic [3:0]  m_err;

   always #5 clk = ~clk;

   axi_lite_beat_monitor u0 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr), .freeze_i(frz),
      .aw_valid_i(vld[0]), .aw_ready_i(rdy[0]), .w_valid_i(vld[1]), .w_ready_i(rdy[1]),
      .b_valid_i(vld[2]), .b_ready_i(rdy[2]), .ar_valid_i(vld[3]), .ar_ready_i(rdy[3]),
      .r_valid_i(vld[4]), .r_ready_i(rdy[4]),
      .aw_cnt_o(u0_aw_cnt), .w_cnt_o(u0_w_cnt), .b_cnt_o(u0_b_cnt), .ar_cnt_o(u0_ar_cnt),
      .r_cnt_o(u0_r_cnt), .wr_aw_pend_o(u0_aw_pend), .wr_w_pend_o(u0_w_pend),
      .rd_pend_o(u0_rd_pend), .balanced_o(u0_bal), .err_o(u0_err));

   axi_lite_beat_monitor #(.CNT_W(4), .MAX_OUTSTANDING(2), .SATURATE(1'b1)) u1 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr), .freeze_i(frz),
      .aw_valid_i(vld[0]), .aw_ready_i(rdy[0]), .w_valid_i(vld[1]), .w_ready_i(rdy[1]),
      .b_valid_i(vld[2]), .b_ready_i(rdy[2]), .ar_valid_i(vld[3]), .ar_ready_i(rdy[3]),
      .r_valid_i(vld[4]), .r_ready_i(rdy[4]),
      .aw_cnt_o(u1_aw_cnt), .w_cnt_o(u1_w_cnt), .b_cnt_o(u1_b_cnt), .ar_cnt_o(u1_ar_cnt),
      .r_cnt_o(u1_r_cnt), .wr_aw_pend_o(u1_aw_pend), .wr_w_pend_o(u1_w_pend),
      .rd_pend_o(u1_rd_pend), .balanced_o(u1_bal), .err_o(u1_err));

   axi_lite_beat_monitor #(.CNT_W(4), .MAX_OUTSTANDING(16), .SATURATE(1'b0)) u2 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr), .freeze_i(frz),
      .aw_valid_i(vld[0]), .aw_ready_i(rdy[0]), .w_valid_i(vld[1]), .w_ready_i(rdy[1]),
      .b_valid_i(vld[2]), .b_ready_i(rdy[2]), .ar_valid_i(vld[3]), .ar_ready_i(rdy[3]),
      .r_valid_i(vld[4]), .r_ready_i(rdy[4]),
      .aw_cnt_o(u2_aw_cnt), .w_cnt_o(u2_w_cnt), .b_cnt_o(u2_b_cnt), .ar_cnt_o(u2_ar_cnt),
      .r_cnt_o(u2_r_cnt), .wr_aw_pend_o(u2_aw_pend), .wr_w_pend_o(u2_w_pend),
      .rd_pend_o(u2_rd_pend), .balanced_o(u2_bal), .err_o(u2_err));

   // Model: counts accepted beats, tracks open transactions as plain integers.
   task automatic model_update();
      logic [4:0] h;
      logic [3:0] e;
      h = vld & rdy;
      e = 4'b0;
      if (rst) begin
         for (int i = 0; i < 5; i++) m_c[i] = 32'd0;
         m_aw = 0; m_w = 0; m_rd = 0; m_err = 4'b0;
      end else begin
         if (clr) begin
            for (int i = 0; i < 5; i++) m_c[i] = 32'd0;
         end else if (!frz) begin
            for (int i = 0; i < 5; i++) begin
               if (h[i]) begin
                  if (m_c[i] == 32'hFFFF_FFFF) e[3] = 1'b1;
                  else m_c[i] = m_c[i] + 32'd1;
               end
            end
         end
         if (h[2]) begin
            if (m_aw == 0 || m_w == 0) e[0] = 1'b1;
            if (m_aw > 0) m_aw = m_aw - 1;
            if (m_w > 0) m_w = m_w - 1;
         end
         if (h[4]) begin
            if (m_rd == 0) e[1] = 1'b1;
            else m_rd = m_rd - 1;
         end
         if (h[0]) m_aw = m_aw + 1;
         if (h[1]) m_w = m_w + 1;
         if (h[3]) m_rd = m_rd + 1;
         if (m_aw > MAXO) begin m_aw = MAXO; e[2] = 1'b1; end
         if (m_w > MAXO) begin m_w = MAXO; e[2] = 1'b1; end
         if (m_rd > MAXO) begin m_rd = MAXO; e[2] = 1'b1; end
         if (clr) m_err = 4'b0;
         else m_err = m_err | e;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic beat(input logic [4:0] m);
      vld = m; rdy = m;
      step();
      vld = 5'b0; rdy = 5'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; frz = 1'b0; vld = 5'b0; rdy = 5'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({u0_aw_cnt, u0_w_cnt, u0_b_cnt, u0_ar_cnt, u0_r_cnt} !== 160'd0) begin
         errors++; $display("FAIL reset_cnt got %h want 0", {u0_aw_cnt, u0_w_cnt, u0_b_cnt, u0_ar_cnt, u0_r_cnt});
      end
      checks++;
      if ({u0_aw_pend, u0_w_pend, u0_rd_pend} !== 15'd0) begin
         errors++; $display("FAIL reset_pend got %h want 0", {u0_aw_pend, u0_w_pend, u0_rd_pend});
      end
      checks++;
      if ({u0_bal, u0_err} !== 5'b1_0000 || {u1_bal, u1_err} !== 5'b1_0000) begin
         errors++; $display("FAIL reset_bal_err got %b/%b want 10000", {u0_bal, u0_err}, {u1_bal, u1_err});
      end
   endtask

   task automatic test_single_rw();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         beat(M_AW | M_W);
         if (i == 0) begin
            checks++;
            if ({u0_aw_pend, u0_w_pend, u0_bal} !== {5'd1, 5'd1, 1'b0}) begin
               errors++; $display("FAIL rw_open got %0d %0d %b want 1 1 0", u0_aw_pend, u0_w_pend, u0_bal);
            end
         end
         step();
         beat(M_B);
      end
      for (int i = 0; i < 3; i++) begin
         beat(M_AR);
         beat(M_R);
      end
      checks++;
      if ({u0_aw_cnt, u0_w_cnt, u0_b_cnt} !== {32'd5, 32'd5, 32'd5}) begin
         errors++; $display("FAIL rw_wcnt got %0d %0d %0d want 5 5 5", u0_aw_cnt, u0_w_cnt, u0_b_cnt);
      end
      checks++;
      if ({u0_ar_cnt, u0_r_cnt} !== {32'd3, 32'd3}) begin
         errors++; $display("FAIL rw_rcnt got %0d %0d want 3 3", u0_ar_cnt, u0_r_cnt);
      end
      checks++;
      if ({u0_bal, u0_err} !== 5'b1_0000) begin
         errors++; $display("FAIL rw_bal_err got %b want 10000", {u0_bal, u0_err});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 3; i++) beat(M_AW);
      checks++;
      if ({u0_aw_pend, u0_w_pend, u0_bal} !== {5'd3, 5'd0, 1'b0}) begin
         errors++; $display("FAIL b2b_aw got %0d %0d %b want 3 0 0", u0_aw_pend, u0_w_pend, u0_bal);
      end
      for (int i = 0; i < 3; i++) beat(M_W);
      for (int i = 0; i < 3; i++) beat(M_B);
      checks++;
      if ({u0_aw_pend, u0_w_pend, u0_rd_pend, u0_bal, u0_err} !== {15'd0, 1'b1, 4'b0}) begin
         errors++; $display("FAIL b2b_drain got %0d %0d %0d %b %b want 0 0 0 1 0000",
                            u0_aw_pend, u0_w_pend, u0_rd_pend, u0_bal, u0_err);
      end
   endtask

   task automatic test_orphan();
      do_reset();
      beat(M_B);
      checks++;
      if ({u0_err, u0_aw_pend, u0_w_pend, u0_bal, u0_b_cnt} !== {4'b0001, 10'd0, 1'b1, 32'd1}) begin
         errors++; $display("FAIL orphan_b got err %b pend %0d/%0d bal %b bcnt %0d want 0001 0/0 1 1",
                            u0_err, u0_aw_pend, u0_w_pend, u0_bal, u0_b_cnt);
      end
      beat(M_R);
      checks++;
      if ({u0_err, u0_rd_pend} !== {4'b0011, 5'd0}) begin
         errors++; $display("FAIL orphan_r got err %b rd %0d want 0011 0", u0_err, u0_rd_pend);
      end
      clr = 1'b1; step(); clr = 1'b0;
      checks++;
      if ({u0_err, u0_b_cnt, u0_r_cnt} !== {4'b0000, 64'd0}) begin
         errors++; $display("FAIL orphan_clear got err %b b %0d r %0d want 0000 0 0", u0_err, u0_b_cnt, u0_r_cnt);
      end
      beat(M_AW | M_W | M_B);
      checks++;
      if ({u0_err, u0_aw_pend, u0_w_pend} !== {4'b0001, 5'd1, 5'd1}) begin
         errors++; $display("FAIL orphan_same_cycle got err %b pend %0d/%0d want 0001 1/1", u0_err, u0_aw_pend, u0_w_pend);
      end
      beat(M_B);
      checks++;
      if ({u0_err, u0_aw_pend, u0_w_pend, u0_bal} !== {4'b0001, 10'd0, 1'b1}) begin
         errors++; $display("FAIL orphan_sticky got err %b pend %0d/%0d bal %b want 0001 0/0 1",
                            u0_err, u0_aw_pend, u0_w_pend, u0_bal);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         beat(M_AR);
         beat(M_R);
      end
      checks++;
      if ({u1_ar_cnt, u1_r_cnt, u1_err} !== {4'd15, 4'd15, 4'b1000}) begin
         errors++; $display("FAIL sat_hold got ar %0d r %0d err %b want 15 15 1000", u1_ar_cnt, u1_r_cnt, u1_err);
      end
      checks++;
      if ({u2_ar_cnt, u2_r_cnt, u2_err} !== {4'd1, 4'd1, 4'b1000}) begin
         errors++; $display("FAIL sat_wrap got ar %0d r %0d err %b want 1 1 1000", u2_ar_cnt, u2_r_cnt, u2_err);
      end
      checks++;
      if ({u0_ar_cnt, u0_err, u1_rd_pend} !== {32'd17, 4'b0000, 2'd0}) begin
         errors++; $display("FAIL sat_wide got ar %0d err %b u1rd %0d want 17 0000 0", u0_ar_cnt, u0_err, u1_rd_pend);
      end
   endtask

   task automatic test_outstanding();
      do_reset();
      for (int i = 0; i < 3; i++) beat(M_AR);
      checks++;
      if ({u1_rd_pend, u1_err, u0_rd_pend, u0_err} !== {2'd2, 4'b0100, 5'd3, 4'b0000}) begin
         errors++; $display("FAIL outst_rd got u1 %0d %b u0 %0d %b want 2 0100 3 0000",
                            u1_rd_pend, u1_err, u0_rd_pend, u0_err);
      end
      clr = 1'b1; step(); clr = 1'b0;
      checks++;
      if ({u1_err, u1_rd_pend, u0_ar_cnt} !== {4'b0000, 2'd2, 32'd0}) begin
         errors++; $display("FAIL outst_clear got err %b rd %0d ar %0d want 0000 2 0", u1_err, u1_rd_pend, u0_ar_cnt);
      end
      frz = 1'b1;
      for (int i = 0; i < 4; i++) beat(M_W);
      frz = 1'b0;
      checks++;
      if ({u0_w_cnt, u1_w_cnt, u0_w_pend, u1_w_pend, u1_err} !== {32'd0, 4'd0, 5'd4, 2'd2, 4'b0100}) begin
         errors++; $display("FAIL outst_freeze got w %0d/%0d pend %0d/%0d err %b want 0/0 4/2 0100",
                            u0_w_cnt, u1_w_cnt, u0_w_pend, u1_w_pend, u1_err);
      end
      beat(M_W);
      checks++;
      if ({u0_w_cnt, u0_w_pend} !== {32'd1, 5'd5}) begin
         errors++; $display("FAIL outst_unfreeze got w %0d pend %0d want 1 5", u0_w_cnt, u0_w_pend);
      end
   endtask

   task automatic test_random();
      beat_counts_t dut_s, ref_s;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         vld = 5'($urandom_range(0, 31));
         rdy = 5'($urandom_range(0, 31));
         frz = ($urandom_range(0, 7) == 0);
         if (cyc == 200) begin
            rst = 1'b1; vld[0] = 1'b1; rdy[0] = 1'b1;
         end
         step();
         rst = 1'b0;
         if (cyc == 200) begin
            checks++;
            if ({u0_aw_cnt, u0_w_cnt, u0_b_cnt, u0_ar_cnt, u0_r_cnt, u0_aw_pend, u0_w_pend,
                 u0_rd_pend, u0_bal, u0_err, u1_aw_cnt, u2_aw_cnt} !== {175'd0, 1'b1, 4'b0, 8'd0}) begin
               errors++; $display("FAIL rand_midreset got aw %0d pend %0d bal %b err %b want 0 0 1 0000",
                                  u0_aw_cnt, u0_aw_pend, u0_bal, u0_err);
            end
         end
         dut_s = '{aw: u0_aw_cnt, w: u0_w_cnt, b: u0_b_cnt, ar: u0_ar_cnt, r: u0_r_cnt};
         ref_s = '{aw: m_c[0], w: m_c[1], b: m_c[2], ar: m_c[3], r: m_c[4]};
         checks++;
         if (dut_s !== ref_s) begin
            errors++; $display("FAIL rand_cnt cyc %0d got %h want %h", cyc, dut_s, ref_s);
         end
         checks++;
         if ({u0_aw_pend, u0_w_pend, u0_rd_pend} !== {5'(m_aw), 5'(m_w), 5'(m_rd)}) begin
            errors++; $display("FAIL rand_pend cyc %0d got %0d %0d %0d want %0d %0d %0d",
                               cyc, u0_aw_pend, u0_w_pend, u0_rd_pend, m_aw, m_w, m_rd);
         end
         checks++;
         if ({u0_bal, u0_err} !== {(m_aw == 0 && m_w == 0 && m_rd == 0), m_err}) begin
            errors++; $display("FAIL rand_flags cyc %0d got bal %b err %b want err %b", cyc, u0_bal, u0_err, m_err);
         end
      end
      vld = 5'b0; rdy = 5'b0; frz = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_rw();
      test_back_to_back();
      test_orphan();
      test_saturate();
      test_outstanding();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
